// File: rtl/mult_wb_buffer.sv
// mult_wb_buffer: result buffer between the mult/div unit and writeback.
// The unit cannot be back-pressured, so every result is captured in a small
// circular FIFO and offered to writeback through a valid/ready port. stall_o
// warns issue early enough that results still in flight always find a slot.
// Optional macro MULT_WB_BYPASS_EN: when the FIFO is empty and writeback is
// ready, forward the incoming result combinationally (latency 0, not stored).
//
// Writeback handshake: wb_valid_o says the head entry is presented on wb_*;
// a transfer happens on a clock edge where wb_valid_o and wb_ready_i are both
// high and flush_i is low. While wb_valid_o is high and wb_ready_i is low the
// wb_* data stays stable. Under flush_i the handshake is ignored.
module mult_wb_buffer #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int THREAD_NUM    = 2,
    parameter int DEPTH         = 4,
    parameter int INFLIGHT      = 2,
    localparam int TW = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  logic [XLEN-1:0]          in_result_i,
    input  logic [TRANS_ID_BITS-1:0] in_trans_id_i,
    input  logic [TW-1:0]            in_thread_id_i,
    output logic                     stall_o,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [TW-1:0]            wb_thread_id_o,
    output logic [CW-1:0]            count_o,
    output logic                     overflow_o
);

    // Storage: one slot per entry, three parallel arrays indexed by pointer.
    logic [XLEN-1:0]          res_mem [DEPTH];
    logic [TRANS_ID_BITS-1:0] tid_mem [DEPTH];
    logic [TW-1:0]            thr_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic empty;
    logic full;
    logic fifo_pop;
    logic push;
    logic drop;
    logic bypass;

    // Push/pop/drop decisions; flush suppresses all of them.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        fifo_pop = !empty && wb_ready_i && !flush_i;
`ifdef MULT_WB_BYPASS_EN
        bypass   = empty && in_valid_i && wb_ready_i && !flush_i;
`else
        bypass   = 1'b0;
`endif
        // A full FIFO still accepts when the head leaves in the same cycle.
        push     = in_valid_i && !flush_i && !bypass && (!full || fifo_pop);
        drop     = in_valid_i && !flush_i && full && !fifo_pop;
    end

    // Writeback port: head entry when non-empty, zeros (or forwarded input) when empty.
    always_comb begin
        wb_valid_o     = !empty;
        wb_result_o    = '0;
        wb_trans_id_o  = '0;
        wb_thread_id_o = '0;
        if (!empty) begin
            wb_result_o    = res_mem[rd_ptr_q];
            wb_trans_id_o  = tid_mem[rd_ptr_q];
            wb_thread_id_o = thr_mem[rd_ptr_q];
        end
`ifdef MULT_WB_BYPASS_EN
        else if (in_valid_i) begin
            wb_valid_o     = 1'b1;
            wb_result_o    = in_result_i;
            wb_trans_id_o  = in_trans_id_i;
            wb_thread_id_o = in_thread_id_i;
        end
`endif
    end

    // Status outputs come straight from registered state.
    always_comb begin
        stall_o    = (count_q >= CW'(DEPTH - INFLIGHT));
        count_o    = count_q;
        overflow_o = overflow_q;
    end

    // Pointer, occupancy and sticky overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(fifo_pop);
            end
        end
    end

    // Entry write at the tail; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            res_mem[wr_ptr_q] <= in_result_i;
            tid_mem[wr_ptr_q] <= in_trans_id_i;
            thr_mem[wr_ptr_q] <= in_thread_id_i;
        end
    end

endmodule

// File: doc/mult_wb_buffer.md
Name: mult_wb_buffer

Overview:
- Result-side buffer directly downstream of the mult/div functional unit.
- Captures every result the FU emits (multiplier results cannot be back-pressured) in a small FIFO, then presents results to the writeback/scoreboard port with a valid/ready handshake.
- Drives an early-stall signal so that issue stops sending mult ops before the buffer can overflow.
- Carries the hardware thread ID alongside the transaction ID.

Parameters:
- XLEN, 64, result width in bits.
- TRANS_ID_BITS, 3, transaction ID width.
- THREAD_NUM, 2, number of hardware threads; thread ID width TW = max(1, $clog2(THREAD_NUM)).
- DEPTH, 4, FIFO entries; power of two, minimum 4.
- INFLIGHT, 2, maximum results in flight inside the FU after issue is stalled; used for the almost-full threshold.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  controller flush; discards all buffered results
- in_valid_i  input  1  FU result valid (mult_valid_o of FU)
- in_result_i  input  XLEN  FU result
- in_trans_id_i  input  TRANS_ID_BITS  FU transaction ID
- in_thread_id_i  input  TW  FU thread ID
- stall_o  output  1  almost-full; issue must not send new mult ops while high
- wb_valid_o  output  1  head entry valid
- wb_ready_i  input  1  writeback accepts head
- wb_result_o  output  XLEN  head result
- wb_trans_id_o  output  TRANS_ID_BITS  head transaction ID
- wb_thread_id_o  output  TW  head thread ID
- count_o  output  $clog2(DEPTH)+1  current occupancy
- overflow_o  output  1  sticky error: a result arrived while full and was dropped

Behaviour:
- Reset (rst_i high at a clock edge):
  - Read pointer, write pointer and count go to 0; overflow_o goes to 0.
  - Outputs: wb_valid_o=0, stall_o=0, count_o=0.
  - Data outputs read as 0 while empty.
  - Reset mid-operation discards all entries, with no handshake on wb.
- Storage: circular FIFO with DEPTH entries of {result, trans_id, thread_id}.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately.
- Push: in_valid_i=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - The entry is written at the write pointer; the write pointer increments.
- Pop: wb_valid_o & wb_ready_i; the read pointer increments.
- Push and pop in the same cycle: count is unchanged. This is allowed when full (the pop frees the slot) and when count=1.
- Empty: wb_valid_o=0 and data outputs are 0. A push while empty appears on wb the next cycle (latency 1).
- Full without a pop: an arriving result is dropped and overflow_o sets; it holds until reset. The FIFO content is unchanged.
- Output data is the head entry (registered storage) and is stable while wb_valid_o=1 and wb_ready_i=0.
- stall_o = (count >= DEPTH-INFLIGHT), combinational from the registered count.
- flush_i (priority over push and pop):
  - Pointers and count go to 0 at the clock edge; any same-cycle push or pop is ignored; overflow_o is not cleared.
  - wb_valid_o may be 1 in the flush cycle, but writeback ignores the handshake under flush.
- No reordering: results leave in arrival order; thread ID is passed through untouched.

Optional Feature:
- Macro MULT_WB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, in_valid_i=1, wb_ready_i=1 and flush_i=0, the input is forwarded combinationally to wb_* in the same cycle and is not stored (latency 0).
  - When empty and wb_ready_i=0, the result is stored as normal.
  - wb_valid_o = in_valid_i | (count!=0) while empty-bypass applies.
- Not defined: always registered, latency 1; wb_* depend only on state.

Test Plan:
- Reset then idle → wb_valid_o=0, count_o=0, stall_o=0, overflow_o=0; wb_result_o=0.
- Push result 0xDEAD, trans_id 5, thread 1 with wb_ready_i=1 → next cycle wb_valid_o=1, wb_result_o=0xDEAD, wb_trans_id_o=5, wb_thread_id_o=1; popped that cycle, count back to 0. With MULT_WB_BYPASS_EN the values appear in the same cycle and count stays 0.
- wb_ready_i=0, push 3 results (A,B,C) → count_o=3, stall_o=1 once count reaches 2; then wb_ready_i=1 → A,B,C drain in order over 3 cycles, stall_o drops when count<2.
- Fill to 4 with wb_ready_i=0, push a 5th → dropped, overflow_o=1 sticky, count_o=4. In the same state, push plus pop in one cycle → count stays 4, new entry lands at tail.
- 3 entries buffered, assert flush_i with a simultaneous push → next cycle count_o=0, wb_valid_o=0, overflow_o unchanged.
- Push 10 entries with continuous pop → pointer wrap-around; output order and data match input exactly, no overflow.
